// File: rtl/rca8_multibyte_seq.sv
// rtl/rca8_multibyte_seq.sv - byte-serial add/sub sequencer around one RCA8; RCA_SEQ_SAT_EN enables saturating result
module rca8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] s_o,
    output logic       cout_o
);
    always_comb begin : ripple
        logic c;
        c = cin_i;
        for (int i = 0; i < 8; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ c;
            c      = (a_i[i] & b_i[i]) | (a_i[i] & c) | (b_i[i] & c);
        end
        cout_o = c;
    end
endmodule

module rca8_multibyte_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic [8*NBYTES-1:0]   A,
    input  logic [8*NBYTES-1:0]   B,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   S,
    output logic                  Cout,
    output logic                  overflow
);
    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, s_q, s_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [7:0]      add_a, add_b, add_s;
    logic            add_co;
    logic            last_byte, ovf_now;

    assign add_a     = a_q[8*idx_q +: 8];
    assign add_b     = b_q[8*idx_q +: 8];
    assign last_byte = (idx_q == IW'(NBYTES - 1));
    // Sign of the result is the top bit of the final byte, produced in this same cycle.
    assign ovf_now   = (a_q[W-1] == b_q[W-1]) && (add_s[7] != a_q[W-1]);

    rca8 u_rca8 (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (carry_q),
        .s_o    (add_s),
        .cout_o (add_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = op_sub ? ~B : B;
                    carry_d = op_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy               = 1'b1;
                s_d[8*idx_q +: 8]  = add_s;
                carry_d            = add_co;
                if (last_byte) begin
                    state_d = FIN;
                    cout_d  = add_co;
                    ovf_d   = ovf_now;
`ifdef RCA_SEQ_SAT_EN
                    if (ovf_now) begin
                        s_d = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                    end
`endif
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            FIN: begin
                done    = 1'b1;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign S        = s_q;
    assign Cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_rca8_multibyte_seq.sv
// tb/tb_rca8_multibyte_seq.sv - vector table, corner sequences and randomized model check for rca8_multibyte_seq
module tb_rca8_multibyte_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, Cout, overflow;
    logic [W-1:0] S;

    int vectors = 0;
    int miscompares = 0;

    rca8_multibyte_seq #(.NBYTES(NB)) dut (
        .clk(clk), .reset(reset), .start(start), .op_sub(op_sub),
        .A(A), .B(B), .busy(busy), .done(done), .S(S),
        .Cout(Cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference result from signed/unsigned integer arithmetic: {overflow, carry, sum}
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        logic [W:0]   full;
        logic [W-1:0] s;
        int           ia, ib;
        longint       r;
        logic         v;
        ia = a;
        ib = b;
        if (op) begin
            full = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r    = longint'(ia) - longint'(ib);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            r    = longint'(ia) + longint'(ib);
        end
        v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        s = full[W-1:0];
`ifdef RCA_SEQ_SAT_EN
        if (v) s = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {v, full[W], s};
    endfunction

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                         input logic [W-1:0] es, input logic ec, input logic ev);
        int n;
        bit seen;
        int busy_cnt;
        @(posedge clk); #1;
        A = a; B = b; op_sub = op; start = 1'b1;
        n = 0; seen = 0; busy_cnt = 0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (done) seen = 1;
            else if (busy) busy_cnt++;
        end
        chk({tag, "_latency"}, n, 5);
        chk({tag, "_busy_cycles"}, busy_cnt, NB);
        chk({tag, "_busy_in_done"}, busy, 0);
        chk({tag, "_S"}, S, es);
        chk({tag, "_Cout"}, Cout, ec);
        chk({tag, "_ovf"}, overflow, ev);
        @(posedge clk); #1;
        chk({tag, "_done_width"}, done, 0);
        chk({tag, "_S_hold"}, S, es);
    endtask

    vec_t tbl[7];

    initial begin
        logic [W+1:0] m;
        logic [W-1:0] ra, rb;
        logic         rop;
        int           cnt;
        bit           seen;

        tbl[0] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
`ifdef RCA_SEQ_SAT_EN
        tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1, 1'b1};
`else
        tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
`endif
        tbl[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[6] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_S", S, 0);
        chk("rst_Cout", Cout, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++)
            do_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].s, tbl[i].c, tbl[i].v);

        // asynchronous reset between edges clears everything without a clock
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("async_rst_S", S, 0);
        chk("async_rst_Cout", Cout, 0);
        chk("async_rst_ovf", overflow, 0);
        chk("async_rst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // start while busy is ignored
        @(posedge clk); #1;
        A = 32'h1; B = 32'h1; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        A = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) cnt++;
            @(posedge clk); #1;
        end
        chk("busy_start_done_count", cnt, 1);
        chk("busy_start_S", S, 32'h2);

        // start during the done cycle is ignored
        @(posedge clk); #1;
        A = 32'h10; B = 32'h20; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("b2b_first_done", seen, 1);
        A = 32'h1; B = 32'h1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy || done) cnt++;
            @(posedge clk); #1;
        end
        chk("b2b_ignored_activity", cnt, 0);
        chk("b2b_S_kept", S, 32'h30);

        // reset during RUN abandons the operation
        @(posedge clk); #1;
        A = 32'hDEAD_BEEF; B = 32'h1234_5678; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst_S", S, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("midrst_no_done", cnt, 0);
        do_op("after_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = $urandom;
            rop = 1'($urandom_range(0, 1));
            if (i % 10 == 0) ra = {~rb[W-1], rb[W-2:0]};
            if (i % 13 == 0) rb = 32'hFFFF_FFFF;
            m = model(ra, rb, rop);
            do_op($sformatf("rnd%0d", i), ra, rb, rop, m[W-1:0], m[W], m[W+1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rca8_multibyte_seq.md
Name: rca8_multibyte_seq

Overview:
- Sequencer that time-shares a single RCA8 8-bit ripple-carry adder to add or subtract NBYTES-wide operands, one byte per clock, LSB byte first.
- Sits between a requesting datapath (ALU control) and the adder.
- Owns the start/busy/done handshake, operand byte selection, the inter-byte carry register and result assembly.

Parameters:
- NBYTES, 4, operand width in bytes; legal range 2..16; word width W = 8*NBYTES.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- op_sub  input  1  0 = A+B, 1 = A-B; sampled with start
- A  input  W  operand A; sampled with start
- B  input  W  operand B; sampled with start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when the result is valid
- S  output  W  result; held until the next accepted start
- Cout  output  1  carry out of the MSB byte; for subtract, 1 = no borrow
- overflow  output  1  signed overflow of the full W-bit operation

Behaviour:
- Reset, asynchronous, any state: FSM goes to IDLE.
  - busy=0, done=0, S=0, Cout=0, overflow=0.
  - Byte index and carry register cleared.
  - Any in-flight operation is abandoned with no done pulse.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - On start=1, latch A, B and op_sub.
  - If op_sub=1, latch B as ~B.
  - Carry register <= op_sub. Byte index <= 0. Go to RUN.
- RUN, one byte per cycle:
  - Adder inputs are A_8 = A[8i+7:8i], B_8 = Bl[8i+7:8i] and Cin = carry register.
  - S byte i <= S_8. Carry register <= adder Cout.
  - If i = NBYTES-1, go to FIN; otherwise i <= i+1.
- FIN:
  - done=1 for exactly one cycle; busy=0 in the same cycle.
  - Cout = final carry register.
  - overflow = (A[W-1] == Bl[W-1]) && (S[W-1] != A[W-1]).
  - Go to IDLE.
- Latency: start sampled at edge 0 -> busy=1 on edges 1..NBYTES -> done=1 after edge NBYTES+1. Total NBYTES+1 cycles.
- start while busy or in FIN is ignored and not queued; operands are not re-latched.
- S bytes update progressively during RUN.
  - Consumers read S only when done=1 or afterwards.
  - S, Cout and overflow hold their values in IDLE until the next accepted start.
- Back-to-back operation: start asserted in the cycle done is high is ignored. The earliest accepted start is the first IDLE cycle after FIN.
- The byte index counter wraps only through the FIN->IDLE path; it never exceeds NBYTES-1.
- Exactly one RCA8 instance; no other adder logic in the block.

Optional Feature:
- Macro: RCA_SEQ_SAT_EN.
- Defined: when overflow is detected in FIN, S is clamped instead of wrapped, and overflow is still reported as 1.
  - If A[W-1]=0, S = 0x7F..F (most positive).
  - If A[W-1]=1, S = 0x80..0 (most negative).
  - The clamp is applied in the same FIN cycle as done.
- Undefined: S is the wrapped two's-complement result; no clamp logic is present.

Test Plan (NBYTES=4):
- Reset: assert reset mid-simulation -> busy=0, done=0, S=0x00000000, Cout=0, overflow=0 immediately, with no clock edge required.
- Add: A=0x12345678, B=0x11111111, op_sub=0, start 1 cycle -> done pulse exactly 5 cycles after the start edge; S=0x23456789, Cout=0, overflow=0.
- Full carry ripple: A=0xFFFFFFFF, B=0x00000001, add -> S=0x00000000, Cout=1, overflow=0. Then subtract A=0x00000005, B=0x00000007 -> S=0xFFFFFFFE, Cout=0 (borrow), overflow=0.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, add.
  - Without macro: S=0x80000000, overflow=1.
  - With RCA_SEQ_SAT_EN: S=0x7FFFFFFF, overflow=1.
  - Also A=0x80000000 minus B=0x00000001: without macro S=0x7FFFFFFF; with macro S=0x80000000; overflow=1 in both.
- Start while busy: start A=0x00000001+0x00000001, then re-pulse start with A=0xFFFFFFFF on cycle 2 -> ignored; single done; S=0x00000002.
- Reset mid-operation: start, then assert reset on cycle 2 of RUN -> no done pulse, S=0; a fresh start afterwards completes normally in 5 cycles.
